// File: rtl/dff_pkg.sv
// Shared encodings and width helpers for the stallable delay line.
package dff_pkg;

  // Active-low control encodings
  localparam logic EN_ADVANCE = 1'b0;
  localparam logic EN_HOLD    = 1'b1;
  localparam logic CLR_ACTIVE = 1'b0;
  localparam logic RST_ACTIVE = 1'b0;

  // Smallest w with 2**w >= n (0 for n <= 1)
  function automatic int unsigned clog2_w(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

  // Tap select width; a single-stage line still gets a 1-bit select port
  function automatic int unsigned tap_w(input int unsigned depth);
    return (depth > 1) ? clog2_w(depth) : 1;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One delay-line stage: WIDTH data bits plus a valid bit.
module dff_stage
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  // Next state: clear beats enable, otherwise advance or hold
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr == CLR_ACTIVE) begin
      data_d = RST_VAL;
      vld_d  = 1'b0;
    end else if (en == EN_ADVANCE) begin
      data_d = d;
      vld_d  = d_vld;
    end
  end

  // Stage register with asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q     = data_q;
  assign q_vld = vld_q;

endmodule

// File: rtl/dff_delay_line.sv
// Stallable WIDTH x DEPTH delay line with per-stage valid, mid-line tap
// and an occupancy counter.
module dff_delay_line
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int unsigned      TW      = tap_w(DEPTH),
  parameter int unsigned      CW      = clog2_w(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_vld,
  output logic [CW-1:0]    fill_cnt
);

  logic [DEPTH-1:0][WIDTH-1:0] stg_in_data;
  logic [DEPTH-1:0]            stg_in_vld;
  logic [DEPTH-1:0][WIDTH-1:0] stg_data;
  logic [DEPTH-1:0]            stg_vld;
  logic [CW-1:0]               fill_cnt_d, fill_cnt_q;

  // Stage chain: stage 0 takes d, stage i takes stage i-1
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stg_in_data[i] = d;
      assign stg_in_vld[i]  = d_vld;
    end else begin : g_body
      assign stg_in_data[i] = stg_data[i-1];
      assign stg_in_vld[i]  = stg_vld[i-1];
    end

    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .clr   (clr),
      .d     (stg_in_data[i]),
      .d_vld (stg_in_vld[i]),
      .q     (stg_data[i]),
      .q_vld (stg_vld[i])
    );
  end

  // Occupancy: one word in, one word out per advance
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (clr == CLR_ACTIVE) begin
      fill_cnt_d = '0;
    end else if (en == EN_ADVANCE) begin
      fill_cnt_d = fill_cnt_q + CW'(d_vld) - CW'(stg_vld[DEPTH-1]);
    end
  end

  // Occupancy register, cleared with the stages
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      fill_cnt_q <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Tap mux; any select past the last stage falls back to the last stage
  always_comb begin
    tap_q   = stg_data[DEPTH-1];
    tap_vld = stg_vld[DEPTH-1];
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      if (tap_sel == TW'(i)) begin
        tap_q   = stg_data[i];
        tap_vld = stg_vld[i];
      end
    end
  end

  // A single-stage line has nothing to select
  if (DEPTH == 1) begin : g_no_tap
    logic unused_tap_sel;
    assign unused_tap_sel = ^tap_sel;
  end

  assign q        = stg_data[DEPTH-1];
  assign q_vld    = stg_vld[DEPTH-1];
  assign fill_cnt = fill_cnt_q;

endmodule

// File: tb/tb_dff_delay_line.sv
// Bench for dff_delay_line: a DEPTH=4 line and a DEPTH=3 line with a
// non-zero reset value, both checked against a queue-based model.
module tb_dff_delay_line;

  typedef logic [8:0] ent_t;  // {vld, data}

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic       d_vld;
    logic [7:0] exp_q;
    logic       exp_qvld;
    logic [2:0] exp_fill;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] d;
  logic       d_vld;
  logic [1:0] tap_sel;

  logic [7:0] q4, tap_q4, q3, tap_q3;
  logic       q_vld4, tap_vld4, q_vld3, tap_vld3;
  logic [2:0] fill4;
  logic [1:0] fill3;

  ent_t m4[$];
  ent_t m3[$];

  int n_pass  = 0;
  int n_total = 0;

  dff_delay_line #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
    .tap_sel(tap_sel), .q(q4), .q_vld(q_vld4), .tap_q(tap_q4),
    .tap_vld(tap_vld4), .fill_cnt(fill4)
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h5A)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
    .tap_sel(tap_sel), .q(q3), .q_vld(q_vld3), .tap_q(tap_q3),
    .tap_vld(tap_vld3), .fill_cnt(fill3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m4.delete();
    m3.delete();
    for (int i = 0; i < 4; i++) m4.push_back({1'b0, 8'h00});
    for (int i = 0; i < 3; i++) m3.push_back({1'b0, 8'h5A});
  endtask

  // One clock edge of the reference: reset > clear > advance > hold
  task automatic model_edge();
    if (rst == 1'b0 || clr == 1'b0) begin
      model_reset();
    end else if (en == 1'b0) begin
      m4.push_front({d_vld, d});
      void'(m4.pop_back());
      m3.push_front({d_vld, d});
      void'(m3.pop_back());
    end
  endtask

  function automatic int fill_of(input ent_t m[$]);
    int n;
    n = 0;
    foreach (m[i]) if (m[i][8]) n++;
    return n;
  endfunction

  function automatic ent_t tap_of(input ent_t m[$], input int sel);
    int idx;
    idx = (sel >= m.size()) ? m.size() - 1 : sel;
    return m[idx];
  endfunction

  task automatic check_all(input string tag);
    ent_t e;
    e = m4[m4.size()-1];
    cmp({tag, ".q4"},     32'(q4),       32'(e[7:0]));
    cmp({tag, ".qvld4"},  32'(q_vld4),   32'(e[8]));
    cmp({tag, ".fill4"},  32'(fill4),    32'(fill_of(m4)));
    e = tap_of(m4, int'(tap_sel));
    cmp({tag, ".tap4"},   32'({tap_vld4, tap_q4}), 32'(e));
    e = m3[m3.size()-1];
    cmp({tag, ".q3"},     32'(q3),       32'(e[7:0]));
    cmp({tag, ".qvld3"},  32'(q_vld3),   32'(e[8]));
    cmp({tag, ".fill3"},  32'(fill3),    32'(fill_of(m3)));
    e = tap_of(m3, int'(tap_sel));
    cmp({tag, ".tap3"},   32'({tap_vld3, tap_q3}), 32'(e));
  endtask

  // Spec-derived constants for the DEPTH=4 line
  task automatic chk4(input string tag, input logic [7:0] eq, input logic ev, input logic [2:0] ef);
    cmp({tag, ".q"},    32'(q4),     32'(eq));
    cmp({tag, ".qvld"}, 32'(q_vld4), 32'(ev));
    cmp({tag, ".fill"}, 32'(fill4),  32'(ef));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic c, input logic [7:0] dd, input logic v);
    en = e; clr = c; d = dd; d_vld = v;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 8'h00, 1'b0, 3'd1};
    vecs[1]  = '{1'b0, 1'b1, 8'hB2, 1'b1, 8'h00, 1'b0, 3'd2};
    vecs[2]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 8'h00, 1'b0, 3'd3};
    vecs[3]  = '{1'b0, 1'b1, 8'hD4, 1'b1, 8'hA1, 1'b1, 3'd4};
    vecs[4]  = '{1'b0, 1'b1, 8'hE5, 1'b1, 8'hB2, 1'b1, 3'd4};
    vecs[5]  = '{1'b0, 1'b1, 8'hF6, 1'b0, 8'hC3, 1'b1, 3'd3};
    vecs[6]  = '{1'b1, 1'b1, 8'h77, 1'b1, 8'hC3, 1'b1, 3'd3};
    vecs[7]  = '{1'b0, 1'b1, 8'h07, 1'b1, 8'hD4, 1'b1, 3'd3};
    vecs[8]  = '{1'b0, 1'b1, 8'h08, 1'b1, 8'hE5, 1'b1, 3'd3};
    vecs[9]  = '{1'b0, 1'b1, 8'h09, 1'b1, 8'hF6, 1'b0, 3'd3};
    vecs[10] = '{1'b0, 1'b1, 8'h0A, 1'b1, 8'h07, 1'b1, 3'd4};

    rst = 1'b1; tap_sel = 2'd0;
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    #2;

    // Reset then idle
    rst = 1'b0;
    model_reset();
    step("rst0");
    step("rst1");
    chk4("rst", 8'h00, 1'b0, 3'd0);
    cmp("rst.q3", 32'(q3), 32'h5A);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'(8'h3C ^ (i * 8'h55)), 1'b1);
      step("idle");
      chk4("idle", 8'h00, 1'b0, 3'd0);
    end

    // Basic latency and streaming from the vector table
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].d, vecs[i].d_vld);
      step("vec");
      chk4($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_qvld, vecs[i].exp_fill);
    end

    // Clear with enable deasserted empties a full line
    drive(1'b1, 1'b0, 8'hEE, 1'b1);
    step("clr");
    chk4("clr", 8'h00, 1'b0, 3'd0);

    // Clear together with async reset: reset acts before any edge
    drive(1'b0, 1'b1, 8'hA1, 1'b1);
    step("ld_a");
    drive(1'b0, 1'b1, 8'hB2, 1'b1);
    step("ld_b");
    clr = 1'b0; rst = 1'b0;
    model_reset();
    #1;
    check_all("clr_rst");
    chk4("clr_rst", 8'h00, 1'b0, 3'd0);
    step("clr_rst_hold");
    rst = 1'b1; clr = 1'b1;

    // Stall: A1,B2 loaded, 3 hold cycles, then A1 needs 2 more edges
    tap_sel = 2'd1;
    drive(1'b0, 1'b1, 8'hA1, 1'b1);
    step("st_a");
    drive(1'b0, 1'b1, 8'hB2, 1'b1);
    step("st_b");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'(8'hF0 + i), 1'b1);
      step("stall");
      chk4("stall", 8'h00, 1'b0, 3'd2);
      cmp("stall.tap", 32'({tap_vld4, tap_q4}), 32'h1A1);
    end
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    step("resume1");
    chk4("resume1", 8'h00, 1'b0, 3'd2);
    step("resume2");
    chk4("resume2", 8'hA1, 1'b1, 3'd2);

    // Tap and bubbles: valid pattern 1,0,1,1
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    step("tb_clr");
    drive(1'b0, 1'b1, 8'h10, 1'b1); step("tb0");
    drive(1'b0, 1'b1, 8'h11, 1'b0); step("tb1");
    cmp("tb1.tap_s1", 32'({tap_vld4, tap_q4}), 32'h110);
    tap_sel = 2'd0;
    #1;
    cmp("tb1.tap_s0", 32'({tap_vld4, tap_q4}), 32'h011);
    tap_sel = 2'd1;
    drive(1'b0, 1'b1, 8'h12, 1'b1); step("tb2");
    drive(1'b0, 1'b1, 8'h13, 1'b1); step("tb3");
    chk4("tb3", 8'h10, 1'b1, 3'd3);
    cmp("tb3.tap_s1", 32'({tap_vld4, tap_q4}), 32'h112);
    tap_sel = 2'b11;
    #1;
    check_all("tb_top");
    cmp("tb_top.tap4", 32'({tap_vld4, tap_q4}), 32'({q_vld4, q4}));
    cmp("tb_top.tap3", 32'({tap_vld3, tap_q3}), 32'h011);

    // Async reset between edges with fill_cnt=3
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk4("arst", 8'h00, 1'b0, 3'd0);
    cmp("arst.q3", 32'({q_vld3, q3}), 32'h05A);
    step("arst_hold");
    rst = 1'b1;

    // Random traffic against the model, with occasional mid-cycle resets
    for (int k = 0; k < 400; k++) begin
      en      = ($urandom_range(0, 3) == 0);
      clr     = ($urandom_range(0, 24) != 0);
      d       = 8'($urandom);
      d_vld   = 1'($urandom);
      tap_sel = 2'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rnd_arst");
      end
      step("rnd");
      rst = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
